// File: rtl/id_ex_if.sv
// ID/EX stage signal bundle: decoded instruction, control, forwarding sources and EX-side outputs.
// The master side drives the stage inputs; the slave side is the stage itself.
interface id_ex_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int PC_WIDTH      = 9
);
  logic                     id_valid;
  logic [PC_WIDTH-1:0]      id_pc;
  logic [DATA_WIDTH-1:0]    id_rs1_data;
  logic [DATA_WIDTH-1:0]    id_rs2_data;
  logic [DATA_WIDTH-1:0]    id_imm;
  logic [4:0]               id_rs1;
  logic [4:0]               id_rs2;
  logic [4:0]               id_rd;
  logic [OPCODE_LENGTH-1:0] id_alu_op;
  logic                     id_alu_src;
  logic                     id_reg_write;
  logic                     id_mem_read;

  logic                     stall;
  logic                     flush;

  logic [4:0]               mem_rd;
  logic                     mem_reg_write;
  logic [DATA_WIDTH-1:0]    mem_result;
  logic [4:0]               wb_rd;
  logic                     wb_reg_write;
  logic [DATA_WIDTH-1:0]    wb_result;

  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic [PC_WIDTH-1:0]      PC_Cur;
  logic                     ex_valid;
  logic [4:0]               ex_rd;
  logic                     ex_reg_write;
  logic                     ex_mem_read;
  logic [DATA_WIDTH-1:0]    ex_store_data;
  logic                     hazard_stall;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_alu_op, id_alu_src, id_reg_write, id_mem_read, stall, flush,
           mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
    input  SrcA, SrcB, Operation, PC_Cur, ex_valid, ex_rd, ex_reg_write, ex_mem_read,
           ex_store_data, hazard_stall
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_alu_op, id_alu_src, id_reg_write, id_mem_read, stall, flush,
           mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
    output SrcA, SrcB, Operation, PC_Cur, ex_valid, ex_rd, ex_reg_write, ex_mem_read,
           ex_store_data, hazard_stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding from MEM/WB, load-use hazard detection,
// stall hold with write-back refresh, and flush-to-bubble.
module id_ex_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int PC_WIDTH      = 9
) (
  input logic   clk,
  input logic   reset,
  id_ex_if.slave bus
);

  typedef struct packed {
    logic                     valid;
    logic [PC_WIDTH-1:0]      pc;
    logic [DATA_WIDTH-1:0]    rs1_data;
    logic [DATA_WIDTH-1:0]    rs2_data;
    logic [DATA_WIDTH-1:0]    imm;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic [OPCODE_LENGTH-1:0] alu_op;
    logic                     alu_src;
    logic                     reg_write;
    logic                     mem_read;
  } slot_t;

  slot_t slot, slot_next;

  logic                  mem_hit_rs1, mem_hit_rs2;
  logic                  wb_hit_rs1, wb_hit_rs2;
  logic [DATA_WIDTH-1:0] fwd_rs1, fwd_rs2;
  logic                  load_use;

  // x0 is hard-wired zero, so it never matches a producer.
  assign mem_hit_rs1 = bus.mem_reg_write && (bus.mem_rd != 5'd0) && (bus.mem_rd == slot.rs1);
  assign mem_hit_rs2 = bus.mem_reg_write && (bus.mem_rd != 5'd0) && (bus.mem_rd == slot.rs2);
  assign wb_hit_rs1  = bus.wb_reg_write  && (bus.wb_rd  != 5'd0) && (bus.wb_rd  == slot.rs1);
  assign wb_hit_rs2  = bus.wb_reg_write  && (bus.wb_rd  != 5'd0) && (bus.wb_rd  == slot.rs2);

  assign fwd_rs1 = mem_hit_rs1 ? bus.mem_result : (wb_hit_rs1 ? bus.wb_result : slot.rs1_data);
  assign fwd_rs2 = mem_hit_rs2 ? bus.mem_result : (wb_hit_rs2 ? bus.wb_result : slot.rs2_data);

  assign load_use = slot.valid && slot.mem_read && (slot.rd != 5'd0) && bus.id_valid &&
                    ((bus.id_rs1 == slot.rd) || (bus.id_rs2 == slot.rd));

  always_comb begin
    // NOTE: default assignment first so every path drives slot_next and no latch is inferred.
    slot_next = slot;
    if (bus.flush) begin
      slot_next = '0;
    end else if (bus.stall) begin
      // The producer retires while we wait; capture its value or it is lost for good.
      if (wb_hit_rs1) slot_next.rs1_data = bus.wb_result;
      if (wb_hit_rs2) slot_next.rs2_data = bus.wb_result;
    end else if (load_use) begin
      slot_next = '0;
    end else begin
      slot_next.valid     = bus.id_valid;
      slot_next.pc        = bus.id_pc;
      slot_next.rs1_data  = bus.id_rs1_data;
      slot_next.rs2_data  = bus.id_rs2_data;
      slot_next.imm       = bus.id_imm;
      slot_next.rs1       = bus.id_rs1;
      slot_next.rs2       = bus.id_rs2;
      slot_next.rd        = bus.id_rd;
      slot_next.alu_op    = bus.id_alu_op;
      slot_next.alu_src   = bus.id_alu_src;
      slot_next.reg_write = bus.id_reg_write && bus.id_valid;
      slot_next.mem_read  = bus.id_mem_read && bus.id_valid;
    end
  end

  // NOTE: non-blocking assignment for state so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) slot <= '0;
    else       slot <= slot_next;
  end

  assign bus.SrcA          = fwd_rs1;
  assign bus.SrcB          = slot.alu_src ? slot.imm : fwd_rs2;
  assign bus.ex_store_data = fwd_rs2;
  assign bus.Operation     = slot.alu_op;
  assign bus.PC_Cur        = slot.pc;
  assign bus.ex_valid      = slot.valid;
  assign bus.ex_rd         = slot.rd;
  assign bus.ex_reg_write  = slot.reg_write;
  assign bus.ex_mem_read   = slot.mem_read;
  assign bus.hazard_stall  = load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// compared against an instruction-level reference model.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  id_ex_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .PC_WIDTH(9)) bus ();
  id_ex_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .PC_WIDTH(9)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // Reference model: the instruction currently sitting in EX.
  typedef struct {
    bit        valid;
    bit [8:0]  pc;
    bit [31:0] a, b, imm;
    bit [4:0]  rs1, rs2, rd;
    bit [3:0]  op;
    bit        src, rw, mr;
  } instr_t;

  instr_t m;

  function automatic bit [31:0] model_operand(bit [4:0] r, bit [31:0] held);
    if (r != 0 && bus.mem_reg_write && bus.mem_rd == r) return bus.mem_result;
    if (r != 0 && bus.wb_reg_write  && bus.wb_rd  == r) return bus.wb_result;
    return held;
  endfunction

  function automatic bit model_hazard();
    return m.valid && m.mr && m.rd != 0 && bus.id_valid &&
           (bus.id_rs1 == m.rd || bus.id_rs2 == m.rd);
  endfunction

  function automatic bit [117:0] model_outputs();
    bit [31:0] a, b;
    a = model_operand(m.rs1, m.a);
    b = model_operand(m.rs2, m.b);
    return {a, (m.src ? m.imm : b), m.op, m.pc, m.valid, m.rd, m.rw, m.mr, b, model_hazard()};
  endfunction

  function automatic bit [117:0] dut_outputs();
    return {bus.SrcA, bus.SrcB, bus.Operation, bus.PC_Cur, bus.ex_valid, bus.ex_rd,
            bus.ex_reg_write, bus.ex_mem_read, bus.ex_store_data, bus.hazard_stall};
  endfunction

  // Advance one clock; the model sees the same inputs the DUT samples at the edge.
  task automatic tick();
    instr_t n;
    n = m;
    if (reset || bus.flush) begin
      n = '{default: 0};
    end else if (bus.stall) begin
      if (bus.wb_reg_write && bus.wb_rd != 0 && bus.wb_rd == m.rs1) n.a = bus.wb_result;
      if (bus.wb_reg_write && bus.wb_rd != 0 && bus.wb_rd == m.rs2) n.b = bus.wb_result;
    end else if (model_hazard()) begin
      n = '{default: 0};
    end else begin
      n.valid = bus.id_valid;    n.pc  = bus.id_pc;
      n.a     = bus.id_rs1_data; n.b   = bus.id_rs2_data; n.imm = bus.id_imm;
      n.rs1   = bus.id_rs1;      n.rs2 = bus.id_rs2;      n.rd  = bus.id_rd;
      n.op    = bus.id_alu_op;   n.src = bus.id_alu_src;
      n.rw    = bus.id_reg_write & bus.id_valid;
      n.mr    = bus.id_mem_read  & bus.id_valid;
    end
    @(posedge clk);
    #1;
    m = n;
  endtask

  task automatic drive_idle();
    bus.id_valid = 0; bus.id_pc = '0; bus.id_rs1_data = '0; bus.id_rs2_data = '0;
    bus.id_imm = '0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0;
    bus.id_alu_op = '0; bus.id_alu_src = 0; bus.id_reg_write = 0; bus.id_mem_read = 0;
    bus.stall = 0; bus.flush = 0;
    bus.mem_rd = '0; bus.mem_reg_write = 0; bus.mem_result = '0;
    bus.wb_rd = '0; bus.wb_reg_write = 0; bus.wb_result = '0;
  endtask

  task automatic drive_random_id();
    bus.id_valid     = ($urandom_range(0, 9) < 8);
    bus.id_pc        = 9'($urandom);
    bus.id_rs1_data  = $urandom;
    bus.id_rs2_data  = $urandom;
    bus.id_imm       = $urandom;
    bus.id_rs1       = 5'($urandom_range(0, 7));
    bus.id_rs2       = 5'($urandom_range(0, 7));
    bus.id_rd        = 5'($urandom_range(0, 7));
    bus.id_alu_op    = 4'($urandom);
    bus.id_alu_src   = 1'($urandom);
    bus.id_reg_write = 1'($urandom);
    bus.id_mem_read  = ($urandom_range(0, 2) == 0);
  endtask

  task automatic test_reset();
    drive_idle();
    drive_random_id();
    bus.id_valid = 1;
    reset = 1;
    tick();
    tick();
    total++;
    if (dut_outputs() !== 118'd0) begin
      $display("FAIL reset_outputs: got %h expected 0", dut_outputs());
    end else passed++;
    reset = 0;
    drive_idle();
  endtask

  task automatic test_capture();
    drive_idle();
    bus.id_valid = 1; bus.id_rs1_data = 32'd5; bus.id_imm = 32'd7; bus.id_alu_src = 1;
    bus.id_alu_op = 4'b0010; bus.id_pc = 9'h010; bus.id_rs1 = 5'd1; bus.id_rs2 = 5'd2;
    tick();
    drive_idle();
    total++;
    if ({bus.SrcA, bus.SrcB, bus.Operation, bus.PC_Cur, bus.ex_valid} !==
        {32'd5, 32'd7, 4'b0010, 9'h010, 1'b1}) begin
      $display("FAIL capture: got A=%0d B=%0d op=%b pc=%h v=%b expected A=5 B=7 op=0010 pc=010 v=1",
               bus.SrcA, bus.SrcB, bus.Operation, bus.PC_Cur, bus.ex_valid);
    end else passed++;
  endtask

  task automatic test_forward_priority();
    drive_idle();
    bus.id_valid = 1; bus.id_rs1 = 5'd3; bus.id_rs1_data = 32'd1;
    tick();
    drive_idle();
    bus.mem_rd = 5'd3; bus.mem_result = 32'hAA; bus.mem_reg_write = 1;
    bus.wb_rd  = 5'd3; bus.wb_result  = 32'hBB; bus.wb_reg_write  = 1;
    #1;
    total++;
    if (bus.SrcA !== 32'hAA) $display("FAIL fwd_mem_priority: got %h expected aa", bus.SrcA);
    else passed++;
    bus.mem_reg_write = 0;
    #1;
    total++;
    if (bus.SrcA !== 32'hBB) $display("FAIL fwd_wb: got %h expected bb", bus.SrcA);
    else passed++;
    // Same producers but slot reads x0: no forwarding allowed.
    bus.stall = 0; bus.mem_reg_write = 0; bus.wb_reg_write = 0;
    bus.id_valid = 1; bus.id_rs1 = 5'd0; bus.id_rs1_data = 32'h1234;
    tick();
    drive_idle();
    bus.mem_rd = 5'd0; bus.mem_result = 32'hAA; bus.mem_reg_write = 1;
    bus.wb_rd  = 5'd0; bus.wb_result  = 32'hBB; bus.wb_reg_write  = 1;
    #1;
    total++;
    if (bus.SrcA !== 32'h1234) $display("FAIL fwd_x0: got %h expected 1234", bus.SrcA);
    else passed++;
    drive_idle();
  endtask

  task automatic test_load_use();
    drive_idle();
    bus.id_valid = 1; bus.id_rd = 5'd4; bus.id_mem_read = 1; bus.id_reg_write = 1;
    bus.id_pc = 9'h020;
    tick();
    drive_idle();
    bus.id_valid = 1; bus.id_rs1 = 5'd1; bus.id_rs2 = 5'd4; bus.id_rd = 5'd5;
    bus.id_alu_op = 4'd3; bus.id_pc = 9'h024; bus.id_reg_write = 1;
    #1;
    total++;
    if (bus.hazard_stall !== 1'b1) $display("FAIL load_use_detect: got %b expected 1", bus.hazard_stall);
    else passed++;
    tick();
    total++;
    if ({bus.ex_valid, bus.ex_reg_write, bus.hazard_stall} !== 3'b000)
      $display("FAIL load_use_bubble: got v=%b rw=%b hz=%b expected 000",
               bus.ex_valid, bus.ex_reg_write, bus.hazard_stall);
    else passed++;
    tick();
    total++;
    if ({bus.ex_valid, bus.ex_rd, bus.Operation, bus.PC_Cur, bus.ex_reg_write} !==
        {1'b1, 5'd5, 4'd3, 9'h024, 1'b1})
      $display("FAIL load_use_resume: got v=%b rd=%0d op=%0d pc=%h expected v=1 rd=5 op=3 pc=024",
               bus.ex_valid, bus.ex_rd, bus.Operation, bus.PC_Cur);
    else passed++;
    drive_idle();
  endtask

  task automatic test_stall_wb_refresh();
    drive_idle();
    bus.id_valid = 1; bus.id_rs2 = 5'd6; bus.id_rs2_data = 32'd0; bus.id_pc = 9'h030;
    tick();
    drive_idle();
    bus.stall = 1;
    drive_random_id();
    tick();
    bus.wb_rd = 5'd6; bus.wb_result = 32'h55; bus.wb_reg_write = 1;
    tick();
    bus.wb_reg_write = 0; bus.wb_result = '0;
    tick();
    total++;
    if ({bus.ex_valid, bus.PC_Cur} !== {1'b1, 9'h030})
      $display("FAIL stall_hold: got v=%b pc=%h expected v=1 pc=030", bus.ex_valid, bus.PC_Cur);
    else passed++;
    drive_idle();
    #1;
    total++;
    if (bus.ex_store_data !== 32'h55)
      $display("FAIL stall_wb_refresh: got %h expected 55", bus.ex_store_data);
    else passed++;
  endtask

  task automatic test_flush_vs_stall();
    drive_idle();
    bus.id_valid = 1; bus.id_alu_op = 4'd5; bus.id_pc = 9'h040; bus.id_rd = 5'd7;
    tick();
    drive_idle();
    bus.stall = 1; bus.flush = 1;
    tick();
    total++;
    if ({bus.ex_valid, bus.Operation} !== 5'b0)
      $display("FAIL flush_with_stall: got v=%b op=%b expected v=0 op=0000", bus.ex_valid, bus.Operation);
    else passed++;
    drive_idle();
    bus.id_valid = 1; bus.id_pc = 9'h050; bus.id_rs1_data = 32'h99;
    tick();
    drive_random_id();
    bus.id_valid = 1; bus.stall = 1;
    reset = 1;
    tick();
    total++;
    if (dut_outputs() !== 118'd0)
      $display("FAIL reset_mid_stall: got %h expected 0", dut_outputs());
    else passed++;
    reset = 0; drive_idle();
    bus.id_valid = 1; bus.id_pc = 9'h1AB;
    tick();
    total++;
    if ({bus.ex_valid, bus.PC_Cur} !== {1'b1, 9'h1AB})
      $display("FAIL first_capture_after_reset: got v=%b pc=%h expected v=1 pc=1ab",
               bus.ex_valid, bus.PC_Cur);
    else passed++;
    drive_idle();
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      drive_random_id();
      bus.stall         = ($urandom_range(0, 4) == 0);
      bus.flush         = ($urandom_range(0, 9) == 0);
      reset             = ($urandom_range(0, 39) == 0);
      bus.mem_rd        = 5'($urandom_range(0, 7));
      bus.mem_reg_write = 1'($urandom);
      bus.mem_result    = $urandom;
      bus.wb_rd         = 5'($urandom_range(0, 7));
      bus.wb_reg_write  = 1'($urandom);
      bus.wb_result     = $urandom;
      #1;
      total++;
      if (dut_outputs() !== model_outputs()) begin
        if (errs < 10) $display("FAIL random_cycle_%0d: got %h expected %h", i, dut_outputs(), model_outputs());
        errs++;
      end else passed++;
      tick();
    end
    reset = 0;
    drive_idle();
  endtask

  initial begin
    m = '{default: 0};
    reset = 1;
    drive_idle();
    test_reset();
    test_capture();
    test_forward_priority();
    test_load_use();
    test_stall_wb_refresh();
    test_flush_vs_stall();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, operand/result width; OPCODE_LENGTH, 4, ALU operation code width; PC_WIDTH, 9, program-counter width.
REQ-002 Clock and reset SHALL be: clk in 1, sole clock, rising edge; reset in 1, synchronous, active-high.
REQ-003 ID inputs SHALL be: id_valid in 1, slot holds real instruction; id_pc in PC_WIDTH, instruction PC; id_rs1_data / id_rs2_data in DATA_WIDTH, register-file reads; id_imm in DATA_WIDTH, sign-extended immediate; id_rs1 / id_rs2 / id_rd in 5, register indices; id_alu_op in OPCODE_LENGTH, ALU code; id_alu_src in 1, 1 selects immediate for B; id_reg_write in 1; id_mem_read in 1, load.
REQ-004 Control inputs SHALL be: stall in 1, downstream hold; flush in 1, kill slot (branch/jump taken).
REQ-005 Forwarding inputs SHALL be: mem_rd in 5, mem_reg_write in 1, mem_result in DATA_WIDTH (EX/MEM stage); wb_rd in 5, wb_reg_write in 1, wb_result in DATA_WIDTH (MEM/WB stage).
REQ-006 Outputs SHALL be: SrcA / SrcB out DATA_WIDTH, ALU operands; Operation out OPCODE_LENGTH; PC_Cur out PC_WIDTH; ex_valid out 1; ex_rd out 5; ex_reg_write out 1; ex_mem_read out 1; ex_store_data out DATA_WIDTH, forwarded rs2; hazard_stall out 1, load-use stall request to IF/ID.

Function
REQ-007 Stage SHALL hold one registered slot: valid, pc, rs1/rs2 data, imm, rs1/rs2/rd, alu_op, alu_src, reg_write, mem_read.
REQ-008 Update priority at each rising edge SHALL be: reset > flush > stall > hazard bubble > capture.
REQ-009 Flush SHALL load a bubble: valid=0, reg_write=0, mem_read=0, alu_op=0000, all other fields 0; flush with stall SHALL still load the bubble.
REQ-010 Stall (no flush) SHALL hold all slot fields, except REQ-011.
REQ-011 While stalled, if wb_reg_write=1, wb_rd!=0 and wb_rd equals slot rs1 (rs2), slot rs1 (rs2) data SHALL be overwritten with wb_result so the write-back value is not lost.
REQ-012 hazard_stall SHALL be combinational: ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (id_rs1==ex_rd | id_rs2==ex_rd).
REQ-013 hazard_stall=1 with stall=0 and flush=0 SHALL load a bubble (REQ-009 fields); the ID instruction is held upstream and captured the following cycle.
REQ-014 Capture SHALL copy all id_* fields; slot reg_write and mem_read SHALL be ANDed with id_valid.
REQ-015 Forwarded rs1 value SHALL be: mem_result if mem_reg_write & mem_rd!=0 & mem_rd==slot rs1; else wb_result if wb_reg_write & wb_rd!=0 & wb_rd==slot rs1; else slot rs1 data; rs2 identical with slot rs2.
REQ-016 SrcA SHALL equal forwarded rs1; SrcB SHALL equal slot imm if slot alu_src=1, else forwarded rs2; ex_store_data SHALL always equal forwarded rs2.
REQ-017 Operation, PC_Cur, ex_rd, ex_valid, ex_reg_write, ex_mem_read SHALL drive directly from the slot registers; forwarding paths are combinational, zero added latency.
REQ-018 Latency ID->outputs SHALL be exactly one clock when unstalled; throughput one instruction per clock.
REQ-019 Register x0 SHALL never be a forwarding or hazard match.

Reset
REQ-020 reset=1 at a rising edge SHALL clear every slot field to 0, regardless of stall/flush/hazard.
REQ-021 After reset outputs SHALL be: SrcA=0, SrcB=0, Operation=0000, PC_Cur=0, ex_valid=0, ex_rd=0, ex_reg_write=0, ex_mem_read=0, ex_store_data=0, hazard_stall=0.
REQ-022 Reset asserted mid-stall SHALL discard the held instruction; first capture SHALL occur on the first edge with reset=0.

Verification
REQ-023 Capture: id_valid=1, id_rs1_data=5, id_imm=7, id_alu_src=1, id_alu_op=0010, id_pc=0x010 -> next cycle SrcA=5, SrcB=7, Operation=0010, PC_Cur=0x010, ex_valid=1.
REQ-024 Forward priority: slot rs1=3, rs1 data=1, mem_rd=3/mem_result=0xAA, wb_rd=3/wb_result=0xBB, both write enables 1 -> SrcA=0xAA; drop mem_reg_write -> SrcA=0xBB; rs1=0 with same inputs -> SrcA=slot data.
REQ-025 Load-use: slot lw rd=4 (mem_read=1), id_valid=1, id_rs2=4 -> hazard_stall=1; next edge slot is bubble (ex_valid=0, ex_reg_write=0); following edge captures the held instruction.
REQ-026 Stall + WB refresh: slot rs2=6 data=0, stall=1 for 3 cycles, wb_rd=6/wb_result=0x55 on cycle 2 -> after release ex_store_data=0x55 with no WB match.
REQ-027 Flush vs stall: stall=1 and flush=1 same edge -> ex_valid=0, Operation=0000; reset=1 with id_valid=1 -> all outputs per REQ-021.
